// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg: shared types and constants for the writeback arbiter.
//   WB_PAYLOAD_t  - default-width result payload carried through the per-unit FIFOs.
//   WB_SRC_*      - requester index of each execution unit (also the wb_src encoding).
package wb_arbiter_pkg;

  localparam int unsigned ROB_WIDTH_DEF  = 4;
  localparam int unsigned PHY_WIDTH_DEF  = 6;
  localparam int unsigned DATA_WIDTH_DEF = 32;

  localparam int unsigned WB_SRC_ALU    = 0;
  localparam int unsigned WB_SRC_LOAD   = 1;
  localparam int unsigned WB_SRC_STORE  = 2;
  localparam int unsigned WB_SRC_BRANCH = 3;

  typedef struct packed {
    logic [ROB_WIDTH_DEF-1:0]  rob_id;
    logic [PHY_WIDTH_DEF-1:0]  rd_phy;
    logic                      rd_we;
    logic [DATA_WIDTH_DEF-1:0] data;
  } WB_PAYLOAD_t;

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: single-requester result FIFO with registered occupancy.
//   clk, rst    - clock, asynchronous active-high reset
//   flush_i     - synchronous clear of all entries (wins over push/pop)
//   push_i      - producer valid; accepted only while ready_o is high
//   wdata_i     - payload to enqueue
//   pop_i       - consume the head this edge (ignored when empty)
//   rdata_o     - current head payload
//   ready_o     - count != BUF_DEPTH, from registered state only
//   nonempty_o  - count != 0
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned BUF_DEPTH = 2,
  parameter type payload_t = WB_PAYLOAD_t
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     flush_i,
  input  logic     push_i,
  input  payload_t wdata_i,
  input  logic     pop_i,
  output payload_t rdata_o,
  output logic     ready_o,
  output logic     nonempty_o
);

  localparam int unsigned CntW = $clog2(BUF_DEPTH + 1);
  localparam int unsigned PtrW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [CntW-1:0] Full    = CntW'(BUF_DEPTH);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(BUF_DEPTH - 1);

  logic [CntW-1:0] count_q, count_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  payload_t        mem_q [BUF_DEPTH];

  logic push, pop;

  assign ready_o    = (count_q != Full);
  assign nonempty_o = (count_q != '0);
  assign rdata_o    = mem_q[rd_ptr_q];

  assign push = push_i && ready_o;
  assign pop  = pop_i && nonempty_o;

  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (flush_i) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: shares NUM_WB registered writeback ports among NUM_REQ execution units
// (0 ALU, 1 LOAD, 2 STORE, 3 BRANCH). Each unit feeds a private wb_fifo; a round-robin
// scheduler grants up to NUM_WB nonempty heads per cycle starting at rr_ptr.
//   clk, rst                 - clock, asynchronous active-high reset
//   flush_i                  - synchronous flush, drops all buffered and in-flight results
//   req_valid_i/req_ready_o  - per-unit push handshake
//   req_rob_id_i, req_rd_phy_i, req_rd_we_i, req_data_i - per-unit payload
//   wb_valid_o, wb_src_o, wb_rob_id_o, wb_rd_phy_o, wb_rd_we_o, wb_data_o - writeback ports
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned NUM_WB     = 2,
  parameter int unsigned BUF_DEPTH  = 2,
  parameter int unsigned ROB_WIDTH  = 4,
  parameter int unsigned PHY_WIDTH  = 6,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush_i,
  input  logic [NUM_REQ-1:0]                  req_valid_i,
  output logic [NUM_REQ-1:0]                  req_ready_o,
  input  logic [NUM_REQ-1:0][ROB_WIDTH-1:0]   req_rob_id_i,
  input  logic [NUM_REQ-1:0][PHY_WIDTH-1:0]   req_rd_phy_i,
  input  logic [NUM_REQ-1:0]                  req_rd_we_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_data_i,
  output logic [NUM_WB-1:0]                   wb_valid_o,
  output logic [NUM_WB-1:0][1:0]              wb_src_o,
  output logic [NUM_WB-1:0][ROB_WIDTH-1:0]    wb_rob_id_o,
  output logic [NUM_WB-1:0][PHY_WIDTH-1:0]    wb_rd_phy_o,
  output logic [NUM_WB-1:0]                   wb_rd_we_o,
  output logic [NUM_WB-1:0][DATA_WIDTH-1:0]   wb_data_o
);

  localparam int unsigned RrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef struct packed {
    logic [ROB_WIDTH-1:0]  rob_id;
    logic [PHY_WIDTH-1:0]  rd_phy;
    logic                  rd_we;
    logic [DATA_WIDTH-1:0] data;
  } payload_t;

  logic [NUM_REQ-1:0] nonempty;
  logic [NUM_REQ-1:0] pop;
  payload_t           head [NUM_REQ];

  logic [RrW-1:0]     rr_q, rr_d;
  logic [NUM_WB-1:0]  gnt_valid;
  logic [RrW-1:0]     gnt_idx [NUM_WB];

  logic [NUM_WB-1:0]                  wb_valid_q, wb_valid_d;
  logic [NUM_WB-1:0][1:0]             wb_src_q, wb_src_d;
  logic [NUM_WB-1:0][ROB_WIDTH-1:0]   wb_rob_id_q, wb_rob_id_d;
  logic [NUM_WB-1:0][PHY_WIDTH-1:0]   wb_rd_phy_q, wb_rd_phy_d;
  logic [NUM_WB-1:0]                  wb_rd_we_q, wb_rd_we_d;
  logic [NUM_WB-1:0][DATA_WIDTH-1:0]  wb_data_q, wb_data_d;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_fifo
    payload_t wdata;
    assign wdata = '{rob_id: req_rob_id_i[i], rd_phy: req_rd_phy_i[i],
                     rd_we: req_rd_we_i[i], data: req_data_i[i]};

    wb_fifo #(
      .BUF_DEPTH (BUF_DEPTH),
      .payload_t (payload_t)
    ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .flush_i    (flush_i),
      .push_i     (req_valid_i[i]),
      .wdata_i    (wdata),
      .pop_i      (pop[i]),
      .rdata_o    (head[i]),
      .ready_o    (req_ready_o[i]),
      .nonempty_o (nonempty[i])
    );
  end

  // Walk requesters in rotated order from rr_q; the k-th nonempty one seen takes port k.
  // The walk covers NUM_REQ positions only, so it never wraps past rr_q.
  always_comb begin
    logic [RrW-1:0] idx;
    logic [RrW-1:0] last;
    int unsigned    rank;
    logic           any;
    pop       = '0;
    gnt_valid = '0;
    gnt_idx   = '{default: '0};
    idx       = '0;
    last      = '0;
    rank      = 0;
    any       = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = RrW'((int'(rr_q) + i) % NUM_REQ);
      if (nonempty[idx]) begin
        for (int k = 0; k < NUM_WB; k++) begin
          if (rank == unsigned'(k)) begin
            gnt_valid[k] = 1'b1;
            gnt_idx[k]   = idx;
            pop[idx]     = 1'b1;
            last         = idx;
            any          = 1'b1;
          end
        end
        rank = rank + 1;
      end
    end

    if (flush_i)  rr_d = '0;
    else if (any) rr_d = RrW'((int'(last) + 1) % NUM_REQ);
    else          rr_d = rr_q;
  end

  always_comb begin
    wb_valid_d  = '0;
    wb_src_d    = '0;
    wb_rob_id_d = '0;
    wb_rd_phy_d = '0;
    wb_rd_we_d  = '0;
    wb_data_d   = '0;
    if (!flush_i) begin
      for (int k = 0; k < NUM_WB; k++) begin
        if (gnt_valid[k]) begin
          wb_valid_d[k]  = 1'b1;
          wb_src_d[k]    = 2'(gnt_idx[k]);
          wb_rob_id_d[k] = head[gnt_idx[k]].rob_id;
          wb_rd_phy_d[k] = head[gnt_idx[k]].rd_phy;
          wb_rd_we_d[k]  = head[gnt_idx[k]].rd_we;
          wb_data_d[k]   = head[gnt_idx[k]].data;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q        <= '0;
      wb_valid_q  <= '0;
      wb_src_q    <= '0;
      wb_rob_id_q <= '0;
      wb_rd_phy_q <= '0;
      wb_rd_we_q  <= '0;
      wb_data_q   <= '0;
    end else begin
      rr_q        <= rr_d;
      wb_valid_q  <= wb_valid_d;
      wb_src_q    <= wb_src_d;
      wb_rob_id_q <= wb_rob_id_d;
      wb_rd_phy_q <= wb_rd_phy_d;
      wb_rd_we_q  <= wb_rd_we_d;
      wb_data_q   <= wb_data_d;
    end
  end

  assign wb_valid_o  = wb_valid_q;
  assign wb_src_o    = wb_src_q;
  assign wb_rob_id_o = wb_rob_id_q;
  assign wb_rd_phy_o = wb_rd_phy_q;
  assign wb_rd_we_o  = wb_rd_we_q;
  assign wb_data_o   = wb_data_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: drives a default wb_arbiter (NUM_WB=2) and a NUM_WB=1 copy with the same
// stimulus. A queue-per-unit reference model predicts each edge; expected writeback ports
// are queued when stimulus is applied and compared after the edge.
module tb_wb_arbiter;

  logic             clk;
  logic             rst;
  logic             flush;
  logic [3:0]       req_valid;
  logic [3:0][3:0]  req_rob_id;
  logic [3:0][5:0]  req_rd_phy;
  logic [3:0]       req_rd_we;
  logic [3:0][31:0] req_data;

  logic [3:0]       ready0;
  logic [1:0]       v0;
  logic [1:0][1:0]  src0;
  logic [1:0][3:0]  rob0;
  logic [1:0][5:0]  phy0;
  logic [1:0]       we0;
  logic [1:0][31:0] data0;

  logic [3:0]       ready1;
  logic [0:0]       v1;
  logic [0:0][1:0]  src1;
  logic [0:0][3:0]  rob1;
  logic [0:0][5:0]  phy1;
  logic [0:0]       we1;
  logic [0:0][31:0] data1;

  wb_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush),
    .req_valid_i  (req_valid),
    .req_ready_o  (ready0),
    .req_rob_id_i (req_rob_id),
    .req_rd_phy_i (req_rd_phy),
    .req_rd_we_i  (req_rd_we),
    .req_data_i   (req_data),
    .wb_valid_o   (v0),
    .wb_src_o     (src0),
    .wb_rob_id_o  (rob0),
    .wb_rd_phy_o  (phy0),
    .wb_rd_we_o   (we0),
    .wb_data_o    (data0)
  );

  wb_arbiter #(.NUM_WB(1)) dut1 (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush),
    .req_valid_i  (req_valid),
    .req_ready_o  (ready1),
    .req_rob_id_i (req_rob_id),
    .req_rd_phy_i (req_rd_phy),
    .req_rd_we_i  (req_rd_we),
    .req_data_i   (req_data),
    .wb_valid_o   (v1),
    .wb_src_o     (src1),
    .wb_rob_id_o  (rob1),
    .wb_rd_phy_o  (phy1),
    .wb_rd_we_o   (we1),
    .wb_data_o    (data1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  rob;
    logic [5:0]  phy;
    logic        we;
    logic [31:0] data;
  } pl_t;

  typedef struct packed {
    logic [1:0]       v;
    logic [1:0][1:0]  src;
    logic [1:0][3:0]  rob;
    logic [1:0][5:0]  phy;
    logic [1:0]       we;
    logic [1:0][31:0] data;
  } wbo_t;

  pl_t  mq [2][4][$];
  int   rr [2];
  wbo_t exp_q0 [$];
  wbo_t exp_q1 [$];

  int n_checks = 0;
  int n_fail   = 0;
  int seq      = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_ready(input int m);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = (mq[m][i].size() != 2);
    return r;
  endfunction

  task automatic model_clear();
    for (int m = 0; m < 2; m++) begin
      for (int r = 0; r < 4; r++) mq[m][r].delete();
      rr[m] = 0;
    end
  endtask

  // Predict one clock edge of instance m with nw writeback ports.
  task automatic model_edge(input int m, input int nw, output wbo_t e);
    logic [3:0] rdy;
    int         n;
    int         last;
    int         idx;
    pl_t        p;
    e    = '0;
    rdy  = exp_ready(m);
    n    = 0;
    last = -1;
    if (flush) begin
      for (int r = 0; r < 4; r++) mq[m][r].delete();
      rr[m] = 0;
      return;
    end
    for (int i = 0; i < 4; i++) begin
      idx = (rr[m] + i) % 4;
      if (mq[m][idx].size() > 0 && n < nw) begin
        p         = mq[m][idx].pop_front();
        e.v[n]    = 1'b1;
        e.src[n]  = 2'(idx);
        e.rob[n]  = p.rob;
        e.phy[n]  = p.phy;
        e.we[n]   = p.we;
        e.data[n] = p.data;
        n++;
        last = idx;
      end
    end
    if (n > 0) rr[m] = (last + 1) % 4;
    for (int r = 0; r < 4; r++) begin
      if (req_valid[r] && rdy[r]) begin
        p = '{rob: req_rob_id[r], phy: req_rd_phy[r], we: req_rd_we[r], data: req_data[r]};
        mq[m][r].push_back(p);
      end
    end
  endtask

  task automatic step();
    wbo_t e0;
    wbo_t e1;
    check_eq("ready0", 64'(ready0), 64'(exp_ready(0)));
    check_eq("ready1", 64'(ready1), 64'(exp_ready(1)));
    model_edge(0, 2, e0);
    exp_q0.push_back(e0);
    model_edge(1, 1, e1);
    exp_q1.push_back(e1);
    @(posedge clk);
    #1;
    e0 = exp_q0.pop_front();
    check_eq("wb_valid0", 64'(v0), 64'(e0.v));
    check_eq("wb_src0", 64'(src0), 64'(e0.src));
    check_eq("wb_rob0", 64'(rob0), 64'(e0.rob));
    check_eq("wb_phy0", 64'(phy0), 64'(e0.phy));
    check_eq("wb_we0", 64'(we0), 64'(e0.we));
    check_eq("wb_data0", data0, e0.data);
    e1 = exp_q1.pop_front();
    check_eq("wb_valid1", 64'(v1), 64'(e1.v[0]));
    check_eq("wb_src1", 64'(src1), 64'(e1.src[0]));
    check_eq("wb_rob1", 64'(rob1), 64'(e1.rob[0]));
    check_eq("wb_phy1", 64'(phy1), 64'(e1.phy[0]));
    check_eq("wb_we1", 64'(we1), 64'(e1.we[0]));
    check_eq("wb_data1", 64'(data1), 64'(e1.data[0]));
  endtask

  task automatic drive(input logic [3:0] v);
    seq++;
    for (int r = 0; r < 4; r++) begin
      req_rob_id[r] = 4'(seq + r);
      req_rd_phy[r] = 6'(seq * 4 + r);
      req_rd_we[r]  = (r < 2);
      req_data[r]   = {8'(r), 24'(seq)};
    end
    req_valid = v;
  endtask

  // Called #1 after an edge: asserts reset between edges and releases it before the next.
  task automatic async_reset();
    #3 rst = 1'b1;
    #1;
    check_eq("rst_valid0", 64'(v0), 64'd0);
    check_eq("rst_data0", data0, 64'd0);
    check_eq("rst_rob0", 64'(rob0), 64'd0);
    check_eq("rst_ready0", 64'(ready0), 64'hF);
    check_eq("rst_valid1", 64'(v1), 64'd0);
    check_eq("rst_ready1", 64'(ready1), 64'hF);
    #1 rst = 1'b0;
    model_clear();
  endtask

  initial begin
    rst        = 1'b1;
    flush      = 1'b0;
    req_valid  = '0;
    req_rob_id = '0;
    req_rd_phy = '0;
    req_rd_we  = '0;
    req_data   = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_valid0", 64'(v0), 64'd0);
    check_eq("reset_src0", 64'(src0), 64'd0);
    check_eq("reset_data0", data0, 64'd0);
    check_eq("reset_ready0", 64'(ready0), 64'hF);
    rst = 1'b0;
    step();

    // Single ALU result: visible two edges after the handshake.
    req_valid     = 4'b0001;
    req_rob_id[0] = 4'd3;
    req_rd_phy[0] = 6'd12;
    req_rd_we[0]  = 1'b1;
    req_data[0]   = 32'hDEAD;
    step();
    check_eq("single_lat_valid", 64'(v0), 64'd0);
    req_valid = '0;
    step();
    check_eq("single_valid", 64'(v0), 64'b01);
    check_eq("single_src", 64'(src0[0]), 64'd0);
    check_eq("single_rob", 64'(rob0[0]), 64'd3);
    check_eq("single_phy", 64'(phy0[0]), 64'd12);
    check_eq("single_data", 64'(data0[0]), 64'hDEAD);
    step();

    // Flush an idle arbiter to bring rr_ptr back to 0.
    flush = 1'b1;
    step();
    flush = 1'b0;

    // All four units at once.
    drive(4'hF);
    step();
    req_valid = '0;
    step();
    check_eq("all4_valid_a", 64'(v0), 64'b11);
    check_eq("all4_src_a", 64'(src0), {60'd0, 2'd1, 2'd0});
    step();
    check_eq("all4_valid_b", 64'(v0), 64'b11);
    check_eq("all4_src_b", 64'(src0), {60'd0, 2'd3, 2'd2});
    repeat (4) step();

    // ALU and BRANCH every cycle: alternation on the single-port copy.
    repeat (12) begin
      drive(4'b1001);
      step();
    end
    req_valid = '0;
    repeat (4) step();

    // Saturate: single-port copy fills its FIFOs and deasserts ready.
    repeat (10) begin
      drive(4'hF);
      step();
    end

    // Flush with buffered results and pushes in the flush cycle.
    flush = 1'b1;
    drive(4'hF);
    step();
    flush     = 1'b0;
    req_valid = '0;
    check_eq("flush_ready0", 64'(ready0), 64'hF);
    check_eq("flush_ready1", 64'(ready1), 64'hF);
    check_eq("flush_valid0", 64'(v0), 64'd0);
    repeat (3) step();

    // Random traffic with rare flushes and an asynchronous reset in the middle.
    for (int it = 0; it < 300; it++) begin
      drive(4'($urandom));
      flush = ($urandom_range(0, 24) == 0);
      step();
      if (it == 150) async_reset();
    end
    flush     = 1'b0;
    req_valid = '0;

    // Reset mid-stream, then first push shows 2-edge latency.
    drive(4'hF);
    step();
    async_reset();
    req_valid     = 4'b0001;
    req_data[0]   = 32'h1234_5678;
    step();
    req_valid = '0;
    check_eq("post_rst_lat", 64'(v0), 64'd0);
    step();
    check_eq("post_rst_valid", 64'(v0), 64'b01);
    check_eq("post_rst_data", 64'(data0[0]), 64'h1234_5678);
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter that shares NUM_WB result/writeback ports among the execution units: ALU, LOAD, STORE and BRANCH. It sits between the functional-unit outputs and the reorder buffer's per-ROB-id finish inputs, physical register file write ports and wakeup broadcast. Each unit pushes completed results into a small private FIFO. A round-robin scheduler grants up to NUM_WB FIFO heads per cycle and drives registered writeback ports.

## Interface
- NUM_REQ, 4: requesters; index 0 ALU, 1 LOAD, 2 STORE, 3 BRANCH.
- NUM_WB, 2: writeback ports per cycle; must satisfy 1 <= NUM_WB <= NUM_REQ.
- BUF_DEPTH, 2: entries per requester FIFO; power of two.
- ROB_WIDTH, 4: ROB id width.
- PHY_WIDTH, 6: physical register id width.
- DATA_WIDTH, 32: result payload width.

- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- flush  in  1  synchronous pipeline flush; discards all buffered results.
- req_valid  in  [NUM_REQ]  result valid, per unit.
- req_ready  out  [NUM_REQ]  FIFO can accept; a push happens when valid && ready at a rising edge.
- req_rob_id  in  [NUM_REQ][ROB_WIDTH]  ROB id of the result.
- req_rd_phy  in  [NUM_REQ][PHY_WIDTH]  destination physical register.
- req_rd_we  in  [NUM_REQ]  result writes a register (0 for store/branch).
- req_data  in  [NUM_REQ][DATA_WIDTH]  result value.
- wb_valid  out  [NUM_WB]  writeback port valid.
- wb_src  out  [NUM_WB][2]  requester index of the port.
- wb_rob_id  out  [NUM_WB][ROB_WIDTH]  ROB id of the result.
- wb_rd_phy  out  [NUM_WB][PHY_WIDTH]  destination physical register.
- wb_rd_we  out  [NUM_WB]  register write enable.
- wb_data  out  [NUM_WB][DATA_WIDTH]  result value.

## Operation
- FIFO ready: req_ready[i] = (count[i] != BUF_DEPTH). It depends on registered count only.
  - A full FIFO popping this cycle still deasserts ready.
  - There is no combinational path from req_valid to req_ready.
- Per-FIFO state:
  - count is clog2(BUF_DEPTH+1) bits.
  - rd_ptr and wr_ptr are clog2(BUF_DEPTH) bits and wrap modulo BUF_DEPTH.
  - Simultaneous push and pop leaves count unchanged.
- Scheduler (combinational, over FIFOs with count != 0):
  - Grant 0 goes to the first nonempty index at or after rr_ptr, modulo NUM_REQ.
  - Grant k goes to the next nonempty index after grant k-1, without wrapping past rr_ptr.
  - There are at most min(NUM_WB, nonempty) grants; no requester is granted twice in a cycle.
- Granted heads pop at the edge. Their payloads register onto wb ports in grant order, with port 0 taking the oldest rr position. Ungranted ports drive wb_valid=0 and payload 0.
- rr_ptr is clog2(NUM_REQ) bits:
  - With at least one grant, it updates to (last granted index + 1) mod NUM_REQ.
  - With no grant, it holds.
- Flush, at the edge where flush=1:
  - All counts and pointers clear; rr_ptr clears to 0; wb_valid clears to 0 next cycle.
  - Pushes and grants in the flush cycle are discarded.
- Flush has priority over push/pop. Reset has priority over flush.

## Timing
- Reset values:
  - wb_valid, wb_src, wb_rob_id, wb_rd_phy, wb_rd_we and wb_data are all 0.
  - rr_ptr=0; all FIFOs empty; req_ready all 1.
- Latency: a push at edge k is eligible in cycle k+1 and appears on wb ports after edge k+1, at minimum 2 edges from handshake.
- wb ports are valid for exactly one cycle per result. There is no downstream backpressure; the ROB and PRF always accept.
- Throughput: each requester gets 1 result per cycle when it holds a grant every cycle. With NUM_REQ=4, NUM_WB=2 and all units busy, each unit is guaranteed 1 grant per 2 cycles.
- Reset asserted mid-operation: all state clears immediately, and buffered results are lost.

## Structure
- typedef_pkg gets WB_PAYLOAD_t {rob_id, rd_phy, rd_we, data}.
- parameter_pkg gets the requester index constants: WB_SRC_ALU=0, WB_SRC_LOAD=1, WB_SRC_STORE=2, WB_SRC_BRANCH=3.
- Sub-module wb_fifo: a single-requester FIFO of WB_PAYLOAD_t with count and ready. It is instantiated NUM_REQ times.
- The top level holds the rr_ptr, the grant logic and the output registers.

## Test plan
- Single push, idle: ALU pushes rob_id=3, rd_phy=12, data=0xDEAD at edge k -> after edge k+1, wb_valid[0]=1, wb_src=0, rob_id=3, rd_phy=12, data=0xDEAD; wb_valid[1]=0; rr_ptr=1.
- All four units push together, rr_ptr=0 -> next cycle ports carry ALU and LOAD; the following cycle STORE and BRANCH; rr_ptr ends at 0.
- Fairness: ALU and BRANCH push every cycle with NUM_WB=1 override -> strict alternation, and neither is granted twice consecutively.
- Backpressure: LOAD pushes 3 results with no grants available -> req_ready[1]=0 after 2 pushes; the third is accepted only after one pop, and order 1,2,3 is preserved.
- Flush with FIFOs holding 5 results -> wb_valid=0 next cycle, req_ready all 1, rr_ptr=0; no stale result ever appears on the wb ports.
- Asynchronous reset mid-stream, between edges -> outputs are 0 immediately; the first post-reset push emerges with 2-edge latency.
